// File: rtl/poc_share_arbiter.sv
// poc_share_arbiter: round-robin sharing of one POC bus; define POC_ARB_TIMEOUT_EN to bound waits with an err pulse
module poc_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                mode,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     ack,
    output logic [2:0]          grant_id,
    output logic                busy,
    output logic [1:0]          poc_rw,
    output logic                poc_addr,
    output logic [7:0]          poc_din,
    input  logic [7:0]          poc_dout,
    input  logic                poc_irq,
    output logic                err
);
    typedef enum logic [2:0] {IDLE, POLL_REQ, POLL_CHK, WRITE, WAIT_IRQ} state_t;
    state_t            state_q, state_d;
    logic [2:0]        grant_q, grant_d, ptr_q, ptr_d, win;
    logic [7:0]        din_q, din_d, win_byte;
    logic              addr_q, addr_d, mode_q, mode_d, pend_q, pend_d;
    logic              found, win_req, tmo;
    logic [NREQ-1:0]   req_rot;
    logic [8*NREQ-1:0] data_rot;
    int                j;
    logic              unused_in;

    assign unused_in = ^poc_dout[6:0] ^ (TIMEOUT == 0);

    // descending scan so the nearest requester above the pointer is assigned last
    always_comb begin
        found    = 1'b0;
        win      = '0;
        win_byte = '0;
        j        = 0;
        req_rot  = '0;
        data_rot = '0;
        for (int k = NREQ; k >= 1; k--) begin
            j        = (int'(ptr_q) + k) % NREQ;
            req_rot  = req >> j;
            data_rot = req_data >> (8 * j);
            if (req_rot[0]) begin
                found    = 1'b1;
                win      = 3'(j);
                win_byte = data_rot[7:0];
            end
        end
    end

    assign win_req = |(req & (NREQ'(1) << grant_q));

`ifdef POC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          waiting;
    assign waiting = state_q inside {POLL_REQ, POLL_CHK, WAIT_IRQ};
    assign tmo     = waiting && cnt_q == CW'(TIMEOUT - 1);
    always_comb cnt_d = (state_d == IDLE) ? '0 : waiting ? cnt_q + CW'(1) : cnt_q;
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        din_d   = din_q;
        mode_d  = mode_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE: if (found && !(mode && pend_q)) begin
                grant_d = win;
                ptr_d   = win;
                din_d   = win_byte;
                mode_d  = mode;
                pend_d  = pend_q | mode;
                state_d = mode ? WRITE : POLL_REQ;
            end
            POLL_REQ: state_d = win_req ? POLL_CHK : IDLE;
            POLL_CHK: state_d = !win_req ? IDLE : poc_dout[7] ? WRITE : POLL_REQ;
            WRITE:    state_d = mode_q ? WAIT_IRQ : IDLE;
            WAIT_IRQ: if (!poc_irq) begin
                state_d = IDLE;
                pend_d  = 1'b0;
            end
            default:  state_d = IDLE;
        endcase
        if (tmo) begin
            state_d = IDLE;
            pend_d  = 1'b0;
        end
        addr_d = (state_d == WRITE) ? 1'b1 : (state_d == POLL_REQ) ? 1'b0 : addr_q;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= 3'(NREQ - 1);
            din_q   <= '0;
            addr_q  <= 1'b0;
            mode_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            din_q   <= din_d;
            addr_q  <= addr_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
        end
    end

    assign ack      = (state_q == WRITE) ? NREQ'(1) << grant_q : '0;
    assign grant_id = grant_q;
    assign busy     = state_q != IDLE;
    assign poc_rw   = (state_q == POLL_REQ) ? 2'b10 : (state_q == WRITE) ? 2'b11 : 2'b00;
    assign poc_addr = addr_q;
    assign poc_din  = din_q;
    assign err      = tmo;
endmodule

// File: tb/tb_poc_share_arbiter.sv
// tb_poc_share_arbiter: directed and random stimulus against a transaction-level reference model
module tb_poc_share_arbiter;
    localparam int NREQ = 4;
`ifdef POC_ARB_TIMEOUT_EN
    localparam int TIMEOUT = 8;
    localparam int NPOLL   = 2;
    localparam int EXP_ERR = 1;
    localparam int EXP_STK = 0;
`else
    localparam int TIMEOUT = 255;
    localparam int NPOLL   = 3;
    localparam int EXP_ERR = 0;
    localparam int EXP_STK = 1;
`endif

    logic              CLK = 1'b0, RSTn = 1'b0, mode = 1'b0, poc_irq = 1'b1;
    logic [NREQ-1:0]   req = '0, ack;
    logic [8*NREQ-1:0] req_data = '0;
    logic [2:0]        grant_id;
    logic              busy, poc_addr, err;
    logic [1:0]        poc_rw;
    logic [7:0]        poc_din, poc_dout = '0;

    int n_cmp = 0, n_bad = 0;

    int         m_ptr, m_grant, m_step, m_cnt;
    logic [7:0] m_din;
    bit         m_addr, m_act, m_mode, m_wr, m_wait, m_pend;

    poc_share_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RSTn(RSTn), .mode(mode), .req(req), .req_data(req_data),
        .ack(ack), .grant_id(grant_id), .busy(busy), .poc_rw(poc_rw),
        .poc_addr(poc_addr), .poc_din(poc_din), .poc_dout(poc_dout),
        .poc_irq(poc_irq), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_ptr = NREQ - 1; m_grant = 0; m_din = '0; m_addr = 0; m_act = 0;
        m_mode = 0; m_wr = 0; m_wait = 0; m_pend = 0; m_step = 0; m_cnt = 0;
    endfunction

    // a stalled wait is any active cycle that is not the write itself
    function automatic bit m_tmo();
`ifdef POC_ARB_TIMEOUT_EN
        return m_act && !m_wr && m_cnt == TIMEOUT - 1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void m_next();
        bit got;
        int w;
        got = 0;
        w   = 0;
        if (m_tmo()) begin
            m_act = 0; m_wait = 0; m_pend = 0;
        end else if (!m_act) begin
            for (int k = 1; k <= NREQ; k++)
                if (!got && req[(m_ptr + k) % NREQ] && !(mode && m_pend)) begin
                    got = 1;
                    w   = (m_ptr + k) % NREQ;
                end
            if (got) begin
                m_grant = w; m_ptr = w; m_din = req_data[8*w +: 8];
                m_mode = mode; m_act = 1; m_step = 0; m_cnt = 0;
                m_wr = mode; m_addr = mode;
                if (mode) m_pend = 1;
            end
        end else if (m_wr) begin
            m_wr = 0;
            if (m_mode) m_wait = 1;
            else        m_act = 0;
        end else if (m_wait) begin
            m_cnt++;
            if (!poc_irq) begin m_wait = 0; m_pend = 0; m_act = 0; end
        end else begin
            m_cnt++;
            if (!req[m_grant])                       m_act = 0;
            else if (m_step % 2 == 1 && poc_dout[7]) begin m_wr = 1; m_addr = 1; end
            else                                     m_step++;
        end
        if (!m_act) m_cnt = 0;
    endfunction

    task automatic compare();
        chk("busy", busy, m_act);
        chk("rw", poc_rw, m_wr ? 2'b11 : (m_act && !m_wait && m_step % 2 == 0) ? 2'b10 : 2'b00);
        chk("addr", poc_addr, m_addr);
        chk("din", poc_din, m_din);
        chk("grant", grant_id, m_grant);
        chk("ack", ack, m_wr ? (1 << m_grant) : 0);
        chk("err", err, m_tmo());
    endtask

    task automatic cycle();
        m_next();
        @(posedge CLK);
        #1 compare();
    endtask

    task automatic do_reset();
        #1 RSTn = 1'b0;
        m_reset();
        #1 compare();
        #1 RSTn = 1'b1;
    endtask

    initial begin
        int lat, n_err;
        int order[$];
        m_reset();
        @(posedge CLK);
        #1 do_reset();

        req_data = {8'h44, 8'h33, 8'h3C, 8'hA5};
        poc_dout = 8'h80;
        req      = 4'b0001;
        lat      = 1;
        while (lat < 40) begin cycle(); lat++; if (ack != 0) break; end
        chk("lat_ready", lat, 4);
        req = '0;
        cycle(); cycle();

        req = 4'b0001;
        lat = 1;
        while (lat < 60) begin
            poc_dout = (lat >= 2 * NPOLL + 3) ? 8'h80 : 8'h00;
            cycle(); lat++;
            if (ack != 0) break;
        end
        chk("lat_poll", lat, 4 + 2 * NPOLL);
        req = '0;
        cycle(); cycle();

        mode = 1'b1;
        req  = 4'b0010;
        cycle();
        chk("irq_ack", ack, 4'b0010);
        chk("irq_din", poc_din, 8'h3C);
        req = 4'b0100;
        repeat (5) cycle();
        chk("irq_hold", grant_id, 1);
        poc_irq = 1'b0;
        cycle();
        poc_irq = 1'b1;
        chk("irq_idle", busy, 0);
        cycle();
        chk("irq_next", ack, 4'b0100);
        req = '0;
        cycle();
        poc_irq = 1'b0;
        cycle();
        poc_irq = 1'b1;
        cycle();

        mode     = 1'b0;
        poc_dout = 8'h00;
        req      = 4'b0001;
        cycle(); cycle();
        req = '0;
        cycle();
        chk("abort_busy", busy, 0);
        cycle();

        req      = 4'b1000;
        poc_dout = 8'h80;
        cycle(); cycle();
        do_reset();

        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req      = 4'b1111;
        for (int c = 0; c < 60 && req != 0; c++) begin
            cycle();
            if (ack != 0) begin
                order.push_back(int'(grant_id));
                chk("rr_byte", poc_din, 8'h11 * (grant_id + 1));
                req = req & ~ack;
            end
        end
        chk("rr_count", order.size(), 4);
        foreach (order[i]) chk("rr_order", order[i], i);
        cycle();
        req = 4'b0001;
        lat = 1;
        while (lat < 40) begin cycle(); lat++; if (ack != 0) break; end
        chk("rr_again", grant_id, 0);
        req = '0;
        cycle();

        poc_dout = 8'h00;
        req      = 4'b0010;
        n_err    = 0;
        repeat (40) begin
            cycle();
            if (err) begin n_err++; req = '0; end
        end
        chk("tmo_err", n_err, EXP_ERR);
        chk("tmo_busy", busy, EXP_STK);
        req = '0;
        cycle(); cycle();

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            poc_dout = 8'($urandom);
            poc_irq  = $urandom_range(0, 3) != 0;
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if ((m_wr && m_grant == i) || $urandom_range(0, 63) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom);
                end
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
